// File: rtl/msdf_op_sequencer_if.sv
// Bundle of every non-clock signal of msdf_op_sequencer.
//   master : the sequencer side (drives busy/done/err, RAM addresses, operands, result writes)
//   slave  : the environment side (job control, RAM read data, multiplier handshake/results)
// Signal groups:
//   job control   : start, src_base, dst_base, count -> busy, done, err
//   operand RAMs  : src_addr -> q_a, q_b (one-cycle read latency)
//   multiplier    : op_valid/op_ready/op_a/op_b out, res_valid/res_data back
//   result RAM    : dst_addr, dst_data, dst_we
//   debug         : fsm_state (current sequencer state encoding)
//
// Operand handshake: a pair transfers in a cycle where op_valid & op_ready are both
// high at the rising edge; while op_valid is high and op_ready is low, op_a/op_b stay
// unchanged and op_valid stays high. res_valid has no ready: every strobe is one result.
interface msdf_op_sequencer_if #(
   parameter int PORT_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] src_base;
   logic [ADDR_WIDTH-1:0] dst_base;
   logic [ADDR_WIDTH-1:0] count;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [PORT_WIDTH-1:0] q_a;
   logic [PORT_WIDTH-1:0] q_b;
   logic                  op_valid;
   logic                  op_ready;
   logic [PORT_WIDTH-1:0] op_a;
   logic [PORT_WIDTH-1:0] op_b;
   logic                  res_valid;
   logic [PORT_WIDTH-1:0] res_data;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic [PORT_WIDTH-1:0] dst_data;
   logic                  dst_we;
   logic [1:0]            fsm_state;

   modport master (
      input  start, src_base, dst_base, count, q_a, q_b, op_ready, res_valid, res_data,
      output busy, done, err, src_addr, op_valid, op_a, op_b, dst_addr, dst_data, dst_we,
             fsm_state
   );

   modport slave (
      output start, src_base, dst_base, count, q_a, q_b, op_ready, res_valid, res_data,
      input  busy, done, err, src_addr, op_valid, op_a, op_b, dst_addr, dst_data, dst_we,
             fsm_state
   );
endinterface

// File: rtl/msdf_op_sequencer.sv
// Sequences operand reads from RAM A / RAM B into an MSDF multiplier and writes the
// in-order results into the result RAM, then pulses done.
// Ports:
//   ram_clock : sole clock, rising edge
//   resetn    : asynchronous active-low reset
//   bus       : msdf_op_sequencer_if.master (job control, RAM ports, multiplier ports,
//               fsm_state debug view)
// State encoding on fsm_state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
module msdf_op_sequencer #(
   parameter int PORT_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
) (
   input logic                 ram_clock,
   input logic                 resetn,
   msdf_op_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] src_base_r;
   logic [ADDR_WIDTH-1:0] dst_base_r;
   logic [ADDR_WIDTH-1:0] count_r;
   logic [ADDR_WIDTH-1:0] rd_cnt;
   logic [ADDR_WIDTH-1:0] wr_cnt;
   logic [ADDR_WIDTH:0]   outstanding;
   logic                  rd_pending;
   logic [PORT_WIDTH-1:0] fifo_a [2];
   logic [PORT_WIDTH-1:0] fifo_b [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            occ;
   logic                  busy_r;
   logic                  done_r;
   logic                  err_r;
   logic                  dst_we_r;
   logic [ADDR_WIDTH-1:0] dst_addr_r;
   logic [PORT_WIDTH-1:0] dst_data_r;

   logic                  op_valid;
   logic                  hs;
   logic [1:0]            occ_after_pop;
   logic                  room;
   logic                  issue_start;
   logic                  issue_run;
   logic                  issue;
   logic                  res_take;
   logic [ADDR_WIDTH-1:0] rd_cnt_nxt;
   logic [ADDR_WIDTH-1:0] wr_cnt_nxt;

   always_comb begin
      op_valid      = (occ != 2'd0);
      hs            = op_valid & bus.op_ready;
      occ_after_pop = occ - {1'b0, hs};
      // Reads in flight plus held entries never exceed the two FIFO slots.
      room          = (occ_after_pop + {1'b0, rd_pending}) < 2'd2;
      // The first read goes out in the start cycle itself so the first operand
      // pair reaches the multiplier two cycles after start.
      issue_start   = (state == IDLE) & bus.start & (bus.count != '0);
      issue_run     = (state == RUN) & (rd_cnt != count_r) & room;
      issue         = issue_start | issue_run;
      rd_cnt_nxt    = rd_cnt + ADDR_WIDTH'(issue_run);
      // A result taken in the same cycle as a handshake is paired with that op.
      res_take      = bus.res_valid & ((outstanding != '0) | hs);
      wr_cnt_nxt    = wr_cnt + ADDR_WIDTH'(res_take);
   end

   assign bus.src_addr  = issue_start       ? bus.src_base :
                          (state == RUN)    ? src_base_r + rd_cnt : '0;
   assign bus.op_valid  = op_valid;
   assign bus.op_a      = fifo_a[rd_ptr];
   assign bus.op_b      = fifo_b[rd_ptr];
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.dst_we    = dst_we_r;
   assign bus.dst_addr  = dst_addr_r;
   assign bus.dst_data  = dst_data_r;
   assign bus.fsm_state = state;

   always_ff @(posedge ram_clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         src_base_r  <= '0;
         dst_base_r  <= '0;
         count_r     <= '0;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
         outstanding <= '0;
         rd_pending  <= 1'b0;
         fifo_a[0]   <= '0;
         fifo_a[1]   <= '0;
         fifo_b[0]   <= '0;
         fifo_b[1]   <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         occ         <= 2'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         dst_we_r    <= 1'b0;
         dst_addr_r  <= '0;
         dst_data_r  <= '0;
      end else begin
         done_r     <= 1'b0;
         dst_we_r   <= 1'b0;
         rd_pending <= issue;
         if (issue_run) rd_cnt <= rd_cnt_nxt;

         // RAM data for the read issued last cycle lands in the FIFO now.
         if (rd_pending) begin
            fifo_a[wr_ptr] <= bus.q_a;
            fifo_b[wr_ptr] <= bus.q_b;
            wr_ptr         <= ~wr_ptr;
         end
         if (hs) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, rd_pending} - {1'b0, hs};

         if (hs & ~res_take)      outstanding <= outstanding + (ADDR_WIDTH+1)'(1);
         else if (res_take & ~hs) outstanding <= outstanding - (ADDR_WIDTH+1)'(1);

         if (bus.res_valid & ~res_take) err_r <= 1'b1;

         if (res_take) begin
            dst_we_r   <= 1'b1;
            dst_addr_r <= dst_base_r + wr_cnt;
            dst_data_r <= bus.res_data;
            wr_cnt     <= wr_cnt_nxt;
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  src_base_r <= bus.src_base;
                  dst_base_r <= bus.dst_base;
                  count_r    <= bus.count;
                  rd_cnt     <= ADDR_WIDTH'(issue_start);
                  wr_cnt     <= '0;
                  err_r      <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= (bus.count == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (rd_cnt_nxt == count_r) state <= DRAIN;
            end
            DRAIN: begin
               if (wr_cnt_nxt == count_r) state <= DONE;
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
